// File: rtl/flash_spi_pkg.sv
// flash_spi_byte_engine shared package: op codes, FSM states,
// and the flash opcodes issued by the host driver.
package flash_spi_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_XFER    = 2'b00;
  localparam op_t OP_CS_LOW  = 2'b01;
  localparam op_t OP_CS_HIGH = 2'b10;
  localparam op_t OP_NOP     = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LO     = 3'd1;
  localparam state_t S_HI     = 3'd2;
  localparam state_t S_CSWAIT = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;
  localparam logic [7:0] CMD_ULBPR = 8'h98;
  localparam logic [7:0] CMD_CE    = 8'hC7;
  localparam logic [7:0] CMD_PP    = 8'h02;

endpackage

// File: rtl/flash_spi_byte_engine_if.sv
// Command/response handshake bundle between the AHB register
// file (master) and the SPI byte engine (slave).
interface flash_spi_byte_engine_if;
  import flash_spi_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  op_t        cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/flash_spi_halfper_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Times both the SCK half-period and the CE# high hold.
module flash_spi_halfper_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tc = (cnt == 8'd0);

endmodule

// File: rtl/flash_spi_byte_engine.sv
// SPI mode-0 byte engine for the QSPI flash pins (single-bit SPI).
// Build option FLASH_SPI_WPHOLD_EN drives WP#/HOLD# high while CE# is low.
module flash_spi_byte_engine #(
  parameter int PRESCALE       = 4,
  parameter int CE_HIGH_CYCLES = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  flash_spi_byte_engine_if.slave   bus,
  output logic                     fm_sck,
  output logic                     fm_ce_n,
  output logic [3:0]               fm_dout,
  output logic [3:0]               fm_douten,
  input  logic [3:0]               fm_din
);
  import flash_spi_pkg::*;

  localparam logic [7:0] HP_LOAD = 8'(PRESCALE - 1);
  localparam logic [7:0] CE_LOAD = 8'(CE_HIGH_CYCLES - 1);

  state_t     state;
  logic [7:0] sreg;
  logic [7:0] rx;
  logic [7:0] rsp_q;
  logic [2:0] bitcnt;
  logic       mosi;
  logic       oe0;
  logic       accept;
  logic       tc;
  logic       load;
  logic [7:0] load_val;
  logic [1:0] wphold;
  logic       unused_din;

  assign unused_din    = ^{fm_din[3:2], fm_din[0]};
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_data  = rsp_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    load     = 1'b0;
    load_val = HP_LOAD;
    unique case (1'b1)
      accept: begin
        load = (bus.cmd_op == OP_XFER) ||
               (bus.cmd_op == OP_CS_HIGH);
        if (bus.cmd_op == OP_CS_HIGH) load_val = CE_LOAD;
      end
      (state == S_LO): load = tc;
      (state == S_HI): load = tc && (bitcnt != 3'd0);
      default: ;
    endcase
  end

  flash_spi_halfper_cnt u_cnt (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      sreg    <= '0;
      rx      <= '0;
      rsp_q   <= '0;
      bitcnt  <= '0;
      mosi    <= 1'b0;
      oe0     <= 1'b0;
      fm_sck  <= 1'b0;
      fm_ce_n <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            unique case (bus.cmd_op)
              OP_XFER: begin
                sreg   <= bus.cmd_data;
                mosi   <= bus.cmd_data[7];
                bitcnt <= 3'd7;
                state  <= S_LO;
              end
              OP_CS_LOW: begin
                fm_ce_n <= 1'b0;
                oe0     <= 1'b1;
                rsp_q   <= '0;
                state   <= S_DONE;
              end
              OP_CS_HIGH: begin
                fm_ce_n <= 1'b1;
                oe0     <= 1'b0;
                state   <= S_CSWAIT;
              end
              default: begin
                rsp_q <= '0;
                state <= S_DONE;
              end
            endcase
          end
        end
        S_LO: begin
          if (tc) begin
            fm_sck <= 1'b1;
            rx     <= {rx[6:0], fm_din[1]};
            state  <= S_HI;
          end
        end
        S_HI: begin
          if (tc) begin
            fm_sck <= 1'b0;
            if (bitcnt == 3'd0) begin
              rsp_q <= rx;
              state <= S_DONE;
            end else begin
              bitcnt <= bitcnt - 3'd1;
              mosi   <= sreg[bitcnt - 3'd1];
              state  <= S_LO;
            end
          end
        end
        S_CSWAIT: begin
          if (tc) begin
            rsp_q <= '0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // WP#/HOLD# sit on SIO[3:2]; SIO[1] is MISO and never driven.
`ifdef FLASH_SPI_WPHOLD_EN
  assign wphold = {2{~fm_ce_n}};
`else
  assign wphold = 2'b00;
`endif

  assign fm_dout   = {wphold, 1'b0, mosi};
  assign fm_douten = {wphold, 1'b0, oe0};

endmodule

// File: tb/tb_flash_spi_byte_engine.sv
// Self-checking bench for flash_spi_byte_engine (PRESCALE=2, CE_HIGH_CYCLES=4)
// with a small JEDEC-ID flash model and a MOSI->MISO loopback mode.
module tb_flash_spi_byte_engine;
  import flash_spi_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       fm_sck;
  logic       fm_ce_n;
  logic [3:0] fm_dout;
  logic [3:0] fm_douten;
  logic [3:0] fm_din;

  flash_spi_byte_engine_if bus();

  flash_spi_byte_engine #(
    .PRESCALE       (2),
    .CE_HIGH_CYCLES (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus.slave),
    .fm_sck    (fm_sck),
    .fm_ce_n   (fm_ce_n),
    .fm_dout   (fm_dout),
    .fm_douten (fm_douten),
    .fm_din    (fm_din)
  );

  always #5 HCLK = ~HCLK;

  localparam int XFER_LAT = 16 * 2 + 1;
  localparam int CSH_LAT  = 4 + 1;

`ifdef FLASH_SPI_WPHOLD_EN
  localparam logic [3:0] OE_CE_LOW = 4'b1101;
  localparam logic [1:0] WP_CE_LOW = 2'b11;
`else
  localparam logic [3:0] OE_CE_LOW = 4'b0001;
  localparam logic [1:0] WP_CE_LOW = 2'b00;
`endif

  int errors = 0;
  int checks = 0;
  bit loopback = 1'b1;

  // sst26wf080b JEDEC-ID responder
  logic [7:0]  jedec [3] = '{8'hBF, 8'h26, 8'h58};
  int unsigned rises = 0;
  logic [7:0]  fl_sr = '0;
  logic [7:0]  fl_cmd = '0;
  logic        fl_so;

  always @(posedge fm_sck or posedge fm_ce_n) begin
    if (fm_ce_n) begin
      rises  <= 0;
      fl_cmd <= '0;
    end else begin
      fl_sr <= {fl_sr[6:0], fm_dout[0]};
      if (rises == 7) fl_cmd <= {fl_sr[6:0], fm_dout[0]};
      rises <= rises + 1;
    end
  end

  always_comb begin
    fl_so = 1'b0;
    if (fl_cmd == CMD_JEDEC && rises >= 8 && rises < 32)
      fl_so = jedec[rises / 8 - 1][7 - (rises % 8)];
  end

  assign fm_din = {2'b00, (loopback ? fm_dout[0] : fl_so), 1'b0};

  int         sck_rises = 0;
  logic [7:0] mosi_cap = '0;
  int         rsp_count = 0;
  int         ce_hi_cnt = 0;
  bit         mon_ce = 1'b0;

  always @(posedge fm_sck) begin
    sck_rises <= sck_rises + 1;
    mosi_cap  <= {mosi_cap[6:0], fm_dout[0]};
  end

  always @(posedge HCLK) if (bus.rsp_valid) rsp_count <= rsp_count + 1;

  always @(negedge HCLK) if (mon_ce && fm_ce_n) ce_hi_cnt <= ce_hi_cnt + 1;

  // lat = HCLK edges from the accept edge to the edge that sees rsp_valid
  task automatic do_cmd(input op_t op, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    int n;
    @(negedge HCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    @(posedge HCLK);
    #1 bus.cmd_valid = 1'b0;
    lat = 1;
    @(negedge HCLK);
    while (!bus.rsp_valid && lat < 200) begin
      @(negedge HCLK);
      lat++;
    end
    rd = bus.rsp_data;
    checks++;
    if (!bus.rsp_valid) begin
      errors++;
      $display("FAIL cmd_timeout op=%0d got no rsp_valid, required one", op);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    HRESETn = 1'b0;
    #23;
    checks++;
    if ({fm_sck, fm_ce_n, fm_dout, fm_douten,
         bus.rsp_valid, bus.rsp_data} !== {1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs got sck=%b ce_n=%b do=%h oe=%h rv=%b rd=%h",
               fm_sck, fm_ce_n, fm_dout, fm_douten, bus.rsp_valid, bus.rsp_data);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_jedec();
    logic [7:0] rd;
    int lat, base;
    loopback = 1'b0;
    do_cmd(OP_CS_LOW, 8'h00, rd, lat);
    checks++;
    if (fm_douten !== OE_CE_LOW || fm_dout[3:2] !== WP_CE_LOW) begin
      errors++;
      $display("FAIL oe_ce_low got oe=%b do32=%b required %b %b",
               fm_douten, fm_dout[3:2], OE_CE_LOW, WP_CE_LOW);
    end
    base = ce_hi_cnt;
    mon_ce = 1'b1;
    do_cmd(OP_XFER, CMD_JEDEC, rd, lat);
    for (int i = 0; i < 3; i++) begin
      do_cmd(OP_XFER, 8'h00, rd, lat);
      checks++;
      if (rd !== jedec[i]) begin
        errors++;
        $display("FAIL jedec_byte%0d got %h required %h", i, rd, jedec[i]);
      end
    end
    mon_ce = 1'b0;
    @(negedge HCLK);
    checks++;
    if (ce_hi_cnt != base) begin
      errors++;
      $display("FAIL jedec_ce_low got %0d high cycles required 0", ce_hi_cnt - base);
    end
    do_cmd(OP_CS_HIGH, 8'h00, rd, lat);
    checks++;
    if (fm_douten !== 4'b0000 || fm_ce_n !== 1'b1 || fm_dout[3:2] !== 2'b00) begin
      errors++;
      $display("FAIL oe_ce_high got oe=%b ce_n=%b required 0000 1", fm_douten, fm_ce_n);
    end
    loopback = 1'b1;
  endtask

  task automatic test_latency_waveform();
    logic [7:0] rd;
    int lat, base;
    base = sck_rises;
    do_cmd(OP_XFER, 8'hA5, rd, lat);
    checks++;
    if (lat != XFER_LAT) begin
      errors++;
      $display("FAIL xfer_latency got %0d required %0d", lat, XFER_LAT);
    end
    checks++;
    if (sck_rises - base != 8) begin
      errors++;
      $display("FAIL sck_rises got %0d required 8", sck_rises - base);
    end
    checks++;
    if (mosi_cap !== 8'hA5) begin
      errors++;
      $display("FAIL mosi_bits got %h required a5", mosi_cap);
    end
    checks++;
    if (fm_sck !== 1'b0) begin
      errors++;
      $display("FAIL sck_idle got %b required 0", fm_sck);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] rd, pat [2];
    int lat;
    pat[0] = 8'h3C;
    pat[1] = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      do_cmd(OP_XFER, pat[i], rd, lat);
      checks++;
      if (rd !== pat[i]) begin
        errors++;
        $display("FAIL loopback got %h required %h", rd, pat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int lat, rsp_lat, ce_lat;
    bit early;
    do_cmd(OP_CS_LOW, 8'h00, rd, lat);
    @(negedge HCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_CS_HIGH;
    @(posedge HCLK);
    #1 bus.cmd_op = OP_CS_LOW;
    rsp_lat = 0;
    ce_lat  = 0;
    early   = 1'b0;
    lat     = 1;
    @(negedge HCLK);
    while (lat < 100) begin
      if (bus.rsp_valid && rsp_lat == 0) rsp_lat = lat;
      if (bus.cmd_ready && rsp_lat == 0) early = 1'b1;
      if (!fm_ce_n) begin
        ce_lat = lat;
        break;
      end
      @(negedge HCLK);
      lat++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (rsp_lat != CSH_LAT) begin
      errors++;
      $display("FAIL cs_high_latency got %0d required %0d", rsp_lat, CSH_LAT);
    end
    checks++;
    if (early || ce_lat != CSH_LAT + 2) begin
      errors++;
      $display("FAIL b2b_cs_low got early=%b ce_lat=%0d required 0 %0d",
               early, ce_lat, CSH_LAT + 2);
    end
    repeat (3) @(negedge HCLK);
  endtask

  task automatic test_reset_mid_xfer();
    logic [7:0] rd;
    int lat, base, n, rbase;
    do_cmd(OP_CS_LOW, 8'h00, rd, lat);
    @(negedge HCLK);
    base = sck_rises;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_XFER;
    bus.cmd_data  = 8'hFF;
    @(posedge HCLK);
    #1 bus.cmd_valid = 1'b0;
    n = 0;
    while (sck_rises - base < 4 && n < 200) begin
      @(posedge HCLK);
      #1 n++;
    end
    rbase = rsp_count;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (fm_sck !== 1'b0 || fm_ce_n !== 1'b1 || fm_douten !== 4'h0) begin
      errors++;
      $display("FAIL abort_outputs got sck=%b ce_n=%b oe=%h required 0 1 0 (rises=%0d)",
               fm_sck, fm_ce_n, fm_douten, sck_rises - base);
    end
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (40) @(negedge HCLK);
    checks++;
    if (rsp_count != rbase) begin
      errors++;
      $display("FAIL abort_no_rsp got %0d pulses required 0", rsp_count - rbase);
    end
    do_cmd(OP_XFER, CMD_WREN, rd, lat);
    checks++;
    if (rd !== CMD_WREN || lat != XFER_LAT) begin
      errors++;
      $display("FAIL post_abort_xfer got %h lat %0d required 06 %0d", rd, lat, XFER_LAT);
    end
  endtask

  task automatic test_random_ops();
    logic [7:0] rd, d, exp_d;
    int lat, exp_lat, rbase;
    op_t op;
    bit ce_low;
    do_cmd(OP_CS_HIGH, 8'h00, rd, lat);
    ce_low = 1'b0;
    @(negedge HCLK);
    rbase = rsp_count;
    for (int i = 0; i < 24; i++) begin
      op = op_t'($urandom_range(0, 3));
      d  = 8'($urandom);
      exp_d   = (op == OP_XFER) ? d : 8'h00;
      exp_lat = (op == OP_XFER) ? XFER_LAT :
                (op == OP_CS_HIGH) ? CSH_LAT : 1;
      if (op == OP_CS_LOW)  ce_low = 1'b1;
      if (op == OP_CS_HIGH) ce_low = 1'b0;
      do_cmd(op, d, rd, lat);
      checks++;
      if (rd !== exp_d || lat != exp_lat) begin
        errors++;
        $display("FAIL rand%0d op=%0d got %h lat %0d required %h %0d",
                 i, op, rd, lat, exp_d, exp_lat);
      end
      checks++;
      if (fm_ce_n !== !ce_low ||
          fm_douten !== (ce_low ? OE_CE_LOW : 4'h0)) begin
        errors++;
        $display("FAIL rand%0d_pins got ce_n=%b oe=%b required %b %b", i,
                 fm_ce_n, fm_douten, !ce_low, ce_low ? OE_CE_LOW : 4'h0);
      end
    end
    @(negedge HCLK);
    checks++;
    if (rsp_count - rbase != 24) begin
      errors++;
      $display("FAIL rsp_pulse_count got %0d required 24", rsp_count - rbase);
    end
  endtask

  initial begin
    test_reset();
    test_jedec();
    test_latency_waveform();
    test_loopback();
    test_back_to_back();
    test_reset_mid_xfer();
    test_random_ops();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
